// File: rtl/operand_fetch_if.sv
// Bundle between decode/bank/forwarding sources (master) and the operand_fetch stage (slave).
interface operand_fetch_if #(
  parameter int DW  = 32,
  parameter int AW  = 6,
  parameter int SCW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic          in_use_rt;
  logic [DW-1:0] in_imm;
  logic          in_reg_write;
  logic          in_mem_read;
  logic [DW-1:0] rf_data1;
  logic [DW-1:0] rf_data2;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_result;
  logic          wb_write;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [DW-1:0] out_store_data;
  logic [AW-1:0] out_rd;
  logic          out_reg_write;
  logic          out_mem_read;
  logic [SCW-1:0] stall_count;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_use_rt, in_imm, in_reg_write, in_mem_read,
    output rf_data1, rf_data2, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_result,
    output wb_write, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_store_data, out_rd, out_reg_write,
    input  out_mem_read, stall_count
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_use_rt, in_imm, in_reg_write, in_mem_read,
    input  rf_data1, rf_data2, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_result,
    input  wb_write, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_store_data, out_rd, out_reg_write,
    output out_mem_read, stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// ID/EX operand stage: forwards EX/MEM and WB results, stalls on load-use, registers operands for the ALU.
module operand_fetch #(
  parameter int DW  = 32,
  parameter int AW  = 6,
  parameter int SCW = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  operand_fetch_if.slave  bus
);

  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_a_q, out_a_d;
  logic [DW-1:0]  out_b_q, out_b_d;
  logic [DW-1:0]  out_store_q, out_store_d;
  logic [AW-1:0]  out_rd_q, out_rd_d;
  logic           out_reg_write_q, out_reg_write_d;
  logic           out_mem_read_q, out_mem_read_d;
  logic [SCW-1:0] stall_q, stall_d;

  logic          ex_fwd_ok;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          load_in_out;
  logic          load_in_ex;
  logic          hazard;
  logic          advance;

  // EX results from a load are not yet available, so only ALU writes forward from EX.
  assign ex_fwd_ok = bus.ex_valid & bus.ex_reg_write & ~bus.ex_mem_read;

  always_comb begin
    rs_val = bus.rf_data1;
    if (ex_fwd_ok && (bus.ex_rd == bus.in_rs))
      rs_val = bus.ex_result;
    else if (bus.wb_write && (bus.wb_rd == bus.in_rs))
      rs_val = bus.wb_data;
  end

  always_comb begin
    rt_val = bus.rf_data2;
    if (ex_fwd_ok && (bus.ex_rd == bus.in_rt))
      rt_val = bus.ex_result;
    else if (bus.wb_write && (bus.wb_rd == bus.in_rt))
      rt_val = bus.wb_data;
  end

  assign load_in_out = out_valid_q & out_mem_read_q & out_reg_write_q &
                       ((out_rd_q == bus.in_rs) | (bus.in_use_rt & (out_rd_q == bus.in_rt)));
  assign load_in_ex  = bus.ex_valid & bus.ex_mem_read & bus.ex_reg_write &
                       ((bus.ex_rd == bus.in_rs) | (bus.in_use_rt & (bus.ex_rd == bus.in_rt)));
  assign hazard      = bus.in_valid & (load_in_out | load_in_ex);
  assign advance     = ~out_valid_q | bus.out_ready;

  assign bus.in_ready = advance & ~hazard & ~bus.flush;

  always_comb begin
    out_valid_d     = out_valid_q;
    out_a_d         = out_a_q;
    out_b_d         = out_b_q;
    out_store_d     = out_store_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    out_mem_read_d  = out_mem_read_q;
    stall_d         = stall_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (advance && hazard) begin
      out_valid_d = 1'b0;
      if (stall_q != {SCW{1'b1}})
        stall_d = stall_q + SCW'(1);
    end else if (advance && bus.in_valid) begin
      out_valid_d     = 1'b1;
      out_a_d         = rs_val;
      out_b_d         = bus.in_use_rt ? rt_val : bus.in_imm;
      out_store_d     = rt_val;
      out_rd_d        = bus.in_rd;
      out_reg_write_d = bus.in_reg_write;
      out_mem_read_d  = bus.in_mem_read;
    end else if (advance) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q     <= 1'b0;
      out_a_q         <= '0;
      out_b_q         <= '0;
      out_store_q     <= '0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
      out_mem_read_q  <= 1'b0;
      stall_q         <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_a_q         <= out_a_d;
      out_b_q         <= out_b_d;
      out_store_q     <= out_store_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_mem_read_q  <= out_mem_read_d;
      stall_q         <= stall_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_a          = out_a_q;
  assign bus.out_b          = out_b_q;
  assign bus.out_store_data = out_store_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_reg_write  = out_reg_write_q;
  assign bus.out_mem_read   = out_mem_read_q;
  assign bus.stall_count    = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding priority, load-use bubbles, backpressure, flush, reset, saturation.
module tb_operand_fetch;
  logic clock;
  logic reset_n;
  int   n_total;
  int   n_pass;

  operand_fetch_if #(.DW(32), .AW(6), .SCW(16)) bus ();

  operand_fetch #(.DW(32), .AW(6), .SCW(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_use_rt = 1'b0; bus.in_imm = '0; bus.in_reg_write = 1'b0; bus.in_mem_read = 1'b0;
    bus.rf_data1 = '0; bus.rf_data2 = '0;
    bus.ex_valid = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.ex_rd = '0; bus.ex_result = '0;
    bus.wb_write = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clock   = 1'b0;
    reset_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_a", bus.out_a, 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_stall", 32'(bus.stall_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Plain capture from the bank.
    bus.in_valid = 1'b1; bus.in_rs = 6'd3; bus.in_rt = 6'd4; bus.in_rd = 6'd9;
    bus.in_use_rt = 1'b1; bus.in_reg_write = 1'b1;
    bus.rf_data1 = 32'h11; bus.rf_data2 = 32'h22;
    #1 check("basic_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("basic_out_valid", 32'(bus.out_valid), 32'd1);
    check("basic_out_a", bus.out_a, 32'h11);
    check("basic_out_b", bus.out_b, 32'h22);
    check("basic_store", bus.out_store_data, 32'h22);
    check("basic_out_rd", 32'(bus.out_rd), 32'd9);
    check("basic_reg_write", 32'(bus.out_reg_write), 32'd1);

    // Forwarding priority: EX over WB over bank; immediate path for B.
    bus.in_rs = 6'd5; bus.in_rt = 6'd5; bus.in_use_rt = 1'b0; bus.in_imm = 32'hFFFF_FFF0;
    bus.rf_data1 = 32'h55; bus.rf_data2 = 32'h66;
    bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd5; bus.ex_result = 32'hAAAA;
    bus.wb_write = 1'b1; bus.wb_rd = 6'd5; bus.wb_data = 32'hBBBB;
    tick();
    check("fwd_ex_a", bus.out_a, 32'hAAAA);
    check("fwd_imm_b", bus.out_b, 32'hFFFF_FFF0);
    check("fwd_ex_store", bus.out_store_data, 32'hAAAA);
    bus.ex_reg_write = 1'b0;
    tick();
    check("fwd_wb_a", bus.out_a, 32'hBBBB);
    check("fwd_wb_store", bus.out_store_data, 32'hBBBB);
    bus.wb_write = 1'b0; bus.ex_valid = 1'b0;
    tick();
    check("fwd_rf_a", bus.out_a, 32'h55);
    check("fwd_rf_store", bus.out_store_data, 32'h66);

    // Load-use: two bubbles, then data from the WB bypass.
    bus.in_rs = 6'd1; bus.in_rt = 6'd2; bus.in_use_rt = 1'b1; bus.in_rd = 6'd7;
    bus.in_reg_write = 1'b1; bus.in_mem_read = 1'b1;
    bus.rf_data1 = 32'h1; bus.rf_data2 = 32'h2;
    tick();
    check("load_out_valid", 32'(bus.out_valid), 32'd1);
    check("load_mem_read", 32'(bus.out_mem_read), 32'd1);
    bus.in_rs = 6'd7; bus.in_rt = 6'd8; bus.in_rd = 6'd10; bus.in_mem_read = 1'b0;
    bus.rf_data1 = 32'hDEAD; bus.rf_data2 = 32'h88;
    #1 check("lu_ready_1", 32'(bus.in_ready), 32'd0);
    tick();
    check("lu_bubble_1", 32'(bus.out_valid), 32'd0);
    check("lu_stall_1", 32'(bus.stall_count), 32'd1);
    bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 6'd7;
    #1 check("lu_ready_2", 32'(bus.in_ready), 32'd0);
    tick();
    check("lu_bubble_2", 32'(bus.out_valid), 32'd0);
    check("lu_stall_2", 32'(bus.stall_count), 32'd2);
    bus.ex_valid = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.wb_write = 1'b1; bus.wb_rd = 6'd7; bus.wb_data = 32'h1234;
    #1 check("lu_ready_3", 32'(bus.in_ready), 32'd1);
    tick();
    check("lu_out_valid", 32'(bus.out_valid), 32'd1);
    check("lu_out_a", bus.out_a, 32'h1234);
    check("lu_out_b", bus.out_b, 32'h88);
    check("lu_stall_hold", 32'(bus.stall_count), 32'd2);

    // Backpressure: outputs frozen while forward sources change.
    bus.out_ready = 1'b0;
    bus.in_rs = 6'd2; bus.in_rt = 6'd3; bus.in_rd = 6'd11;
    bus.rf_data1 = 32'h77; bus.rf_data2 = 32'h99;
    for (int i = 0; i < 3; i++) begin
      bus.wb_data = 32'h5000 + 32'(i);
      bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd2;
      bus.ex_result = 32'h6000 + 32'(i);
      #1 check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_a", bus.out_a, 32'h1234);
      check("bp_out_b", bus.out_b, 32'h88);
    end
    check("bp_stall", 32'(bus.stall_count), 32'd2);
    bus.ex_valid = 1'b0; bus.ex_reg_write = 1'b0; bus.wb_write = 1'b0; bus.out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_next_a", bus.out_a, 32'h77);
    check("bp_next_b", bus.out_b, 32'h99);
    check("bp_next_rd", 32'(bus.out_rd), 32'd11);

    // Flush wins over a simultaneous hazard and valid input.
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd2;
    bus.flush = 1'b1; bus.in_rd = 6'd12; bus.rf_data1 = 32'h31;
    #1 check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_stall", 32'(bus.stall_count), 32'd2);
    check("flush_no_capture", 32'(bus.out_rd), 32'd11);
    bus.flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0;
    tick();
    check("post_flush_valid", 32'(bus.out_valid), 32'd1);
    check("post_flush_a", bus.out_a, 32'h31);
    check("post_flush_rd", 32'(bus.out_rd), 32'd12);

    // Asynchronous reset mid-stream.
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_a", bus.out_a, 32'd0);
    check("arst_out_rd", 32'(bus.out_rd), 32'd0);
    check("arst_stall", 32'(bus.stall_count), 32'd0);
    tick();
    check("arst_no_capture", 32'(bus.out_valid), 32'd0);
    reset_n = 1'b1;

    // Saturation: 2^16+3 hazard cycles.
    bus.in_valid = 1'b1; bus.in_rs = 6'd2;
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd2;
    repeat (65534) tick();
    check("sat_near", 32'(bus.stall_count), 32'hFFFE);
    check("sat_bubble", 32'(bus.out_valid), 32'd0);
    repeat (5) tick();
    check("sat_full", 32'(bus.stall_count), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
